// File: rtl/upload_packer.sv
// Transmit-side framer: turns (cmd, len, payload stream) into AA 44 CMD LEN_H LEN_L PAYLOAD CKSUM.
// Single registered output stage; header byte appears two cycles after an accepted pkt_start.
module upload_packer #(
  parameter logic [7:0] HDR0  = 8'hAA,
  parameter logic [7:0] HDR1  = 8'h44,
  parameter int         LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pkt_start,
  input  logic [7:0]       pkt_cmd,
  input  logic [LEN_W-1:0] pkt_len,
  output logic             pkt_busy,
  output logic             pkt_done,
  input  logic [7:0]       src_data,
  input  logic             src_valid,
  output logic             src_ready,
  output logic [7:0]       usb_upload_data,
  output logic             usb_upload_valid,
  input  logic             usb_upload_ready
);

  typedef enum logic [3:0] {
    S_IDLE, S_H0, S_H1, S_CMD, S_LENH, S_LENL, S_PAY, S_CKS, S_WAIT
  } state_t;

  state_t           state, state_nxt;
  logic [7:0]       cmd_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt;
  logic [7:0]       cksum;
  logic [7:0]       len_h, len_l;
  logic             slot_free;
  logic             start_ok;
  logic             load;
  logic             sum_en;
  logic [7:0]       load_byte;

  assign slot_free = !usb_upload_valid || usb_upload_ready;
  assign start_ok  = (state == S_IDLE) && pkt_start;
  assign len_h     = 8'(len_q >> 8);
  assign len_l     = len_q[7:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (pkt_start) state_nxt = S_H0;
      S_H0:   if (slot_free) state_nxt = S_H1;
      S_H1:   if (slot_free) state_nxt = S_CMD;
      S_CMD:  if (slot_free) state_nxt = S_LENH;
      S_LENH: if (slot_free) state_nxt = S_LENL;
      S_LENL: if (slot_free) state_nxt = (len_q == '0) ? S_CKS : S_PAY;
      S_PAY:  if (src_valid && slot_free && cnt == LEN_W'(1)) state_nxt = S_CKS;
      S_CKS:  if (slot_free) state_nxt = S_WAIT;
      // Checksum byte sits in the output register until the USB side takes it.
      S_WAIT: if (usb_upload_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    load      = 1'b0;
    sum_en    = 1'b0;
    load_byte = 8'h00;
    src_ready = 1'b0;
    case (state)
      S_H0:   begin load = slot_free; load_byte = HDR0; end
      S_H1:   begin load = slot_free; load_byte = HDR1; end
      S_CMD:  begin load = slot_free; load_byte = cmd_q; sum_en = 1'b1; end
      S_LENH: begin load = slot_free; load_byte = len_h; sum_en = 1'b1; end
      S_LENL: begin load = slot_free; load_byte = len_l; sum_en = 1'b1; end
      S_PAY: begin
        src_ready = slot_free;
        load      = slot_free && src_valid;
        load_byte = src_data;
        sum_en    = 1'b1;
      end
      S_CKS:  begin load = slot_free; load_byte = cksum; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      usb_upload_data  <= 8'h00;
      usb_upload_valid <= 1'b0;
      pkt_busy         <= 1'b0;
      pkt_done         <= 1'b0;
      cmd_q            <= 8'h00;
      len_q            <= '0;
      cnt              <= '0;
      cksum            <= 8'h00;
    end else begin
      pkt_done <= 1'b0;
      if (start_ok) begin
        cmd_q    <= pkt_cmd;
        len_q    <= pkt_len;
        cnt      <= pkt_len;
        cksum    <= 8'h00;
        pkt_busy <= 1'b1;
      end
      if (slot_free) begin
        usb_upload_valid <= load;
        if (load) usb_upload_data <= load_byte;
      end
      if (load && sum_en) cksum <= cksum + load_byte;
      if (load && state == S_PAY) cnt <= cnt - LEN_W'(1);
      if (state == S_WAIT && usb_upload_ready) begin
        pkt_busy <= 1'b0;
        pkt_done <= 1'b1;
      end
    end
  end

endmodule
